// File: rtl/oam_dma_pkg.sv
// Shared types and default addresses for the sprite DMA engine.
//   dma_state_t     : engine states (idle passthrough, halt, align, read, write)
//   TrigAddrDefault : CPU write address that starts a DMA ($4014)
//   OamAddrDefault  : OAM data port that receives every DMA write ($2004)
package oam_dma_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHalt,
    StAlign,
    StRead,
    StWrite
  } dma_state_t;

  localparam logic [15:0] TrigAddrDefault = 16'h4014;
  localparam logic [15:0] OamAddrDefault  = 16'h2004;

endpackage

// File: rtl/oam_dma_if.sv
// Bus bundle between the CPU core, the sprite DMA engine and the system bus.
//   cpu_addr/cpu_d_out/cpu_write : CPU core bus outputs
//   d_in                         : system bus read data (same cycle as addr)
//   addr/d_out/write             : system bus as driven by the DMA engine
//   ready                        : CPU ready, 0 stalls the CPU
//   busy                         : DMA engine is in a non-idle state
// Modports: master = the DMA engine, slave = CPU core plus system bus side.
interface oam_dma_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_d_out;
  logic        cpu_write;
  logic [7:0]  d_in;
  logic [15:0] addr;
  logic [7:0]  d_out;
  logic        write;
  logic        ready;
  logic        busy;

  modport master (
    input  cpu_addr, cpu_d_out, cpu_write, d_in,
    output addr, d_out, write, ready, busy
  );

  modport slave (
    output cpu_addr, cpu_d_out, cpu_write, d_in,
    input  addr, d_out, write, ready, busy
  );
endinterface

// File: rtl/oam_dma.sv
// Sprite (OAM) DMA engine between the CPU core and the system bus.
// A CPU write to TrigAddr stalls the CPU and copies the 256-byte page {value,8'h00}
// to OamAddr, one read+write pair per byte. While idle the CPU bus passes straight through.
// Ports:
//   clk   : system clock (CPU clock domain)
//   reset : asynchronous active-low reset
//   bus   : oam_dma_if.master (CPU bus in, system bus out, ready/busy)
// Build option: OAM_DMA_HALT_ON_READ_EN -- the halt state waits while the CPU is still
// writing (RDY is ignored on write cycles) and passes those writes through to the bus.
module oam_dma
  import oam_dma_pkg::*;
#(
  parameter logic [15:0] TrigAddr = TrigAddrDefault,
  parameter logic [15:0] OamAddr  = OamAddrDefault
) (
  input  logic       clk,
  input  logic       reset,
  oam_dma_if.master  bus
);

  dma_state_t  state_q, state_d;
  logic [7:0]  page_q, page_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  data_q, data_d;
  logic        odd_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      page_q  <= 8'h00;
      cnt_q   <= 8'h00;
      data_q  <= 8'h00;
      odd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      odd_q   <= ~odd_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    page_d    = page_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    bus.addr  = bus.cpu_addr;
    bus.d_out = data_q;
    bus.write = 1'b0;

    unique case (state_q)
      StIdle: begin
        bus.d_out = bus.cpu_d_out;
        bus.write = bus.cpu_write;
        // The trigger write itself still reaches the bus.
        if (bus.cpu_write && (bus.cpu_addr == TrigAddr)) begin
          page_d  = bus.cpu_d_out;
          cnt_d   = 8'h00;
          state_d = StHalt;
        end
      end
      StHalt: begin
`ifdef OAM_DMA_HALT_ON_READ_EN
        if (bus.cpu_write) begin
          bus.d_out = bus.cpu_d_out;
          bus.write = 1'b1;
        end else begin
          state_d = odd_q ? StRead : StAlign;
        end
`else
        // Reads must start on an even cycle; odd now means the next cycle is even.
        state_d = odd_q ? StRead : StAlign;
`endif
      end
      StAlign: begin
        state_d = StRead;
      end
      StRead: begin
        bus.addr = {page_q, cnt_q};
        data_d   = bus.d_in;
        state_d  = StWrite;
      end
      StWrite: begin
        bus.addr  = OamAddr;
        bus.write = 1'b1;
        cnt_d     = cnt_q + 8'h01;
        state_d   = (cnt_q == 8'hFF) ? StIdle : StRead;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign bus.ready = (state_q == StIdle);
  assign bus.busy  = (state_q != StIdle);

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: random CPU traffic and random-page DMA transfers
// checked cycle by cycle against a list of expected bus transactions built from the
// transfer rules (halt, optional align, 256 read/write pairs).
module tb_oam_dma;
  import oam_dma_pkg::*;

  localparam logic [15:0] Trig = 16'h4014;
  localparam logic [15:0] Oam  = 16'h2004;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  oam_dma_if bus();

  oam_dma u_dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  logic [7:0] mem [65536];
  assign bus.d_in = mem[bus.addr];

  int checks = 0;
  int failures = 0;
  int cyc;

  // Clock edges seen since reset release; its parity is the CPU cycle parity.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cpu_drive(input logic [15:0] a, input logic [7:0] d, input logic w);
    bus.cpu_addr  = a;
    bus.cpu_d_out = d;
    bus.cpu_write = w;
  endtask

  // One idle cycle: bus must mirror the CPU and ready must stay high.
  task automatic pass_cycle(input logic [15:0] a, input logic [7:0] d, input logic w);
    @(posedge clk);
    #1;
    cpu_drive(a, d, w);
    @(negedge clk);
    check_eq("pass_addr", 32'(bus.addr), 32'(a));
    check_eq("pass_dout", 32'(bus.d_out), 32'(d));
    check_eq("pass_write", 32'(bus.write), 32'(w));
    check_eq("pass_ready", 32'(bus.ready), 32'd1);
    check_eq("pass_busy", 32'(bus.busy), 32'd0);
  endtask

  task automatic pass_rand();
    logic [15:0] a;
    logic w;
    a = 16'($urandom);
    w = 1'($urandom);
    if (a == Trig) a = 16'h4015;
    pass_cycle(a, 8'($urandom), w);
  endtask

  // Runs one DMA of 'page'. 'w_extra' CPU write cycles follow the trigger; 'par' is the
  // required parity of the trigger cycle.
  task automatic run_dma(input logic [7:0] page, input int w_extra, input int par);
    logic [15:0] ea[$];
    logic        ew[$];
    logic [7:0]  ed[$];
    logic [15:0] hold_addr;
    logic [7:0]  ib;
    int          trig_cyc;
    int          stall;
    bit          align;

    // Idle until the next cycle has the requested parity.
    while (((cyc + 1) & 1) != par) pass_rand();

    @(posedge clk);
    #1;
    cpu_drive(Trig, page, 1'b1);
    trig_cyc = cyc;
    @(negedge clk);
    check_eq("trig_addr", 32'(bus.addr), 32'(Trig));
    check_eq("trig_dout", 32'(bus.d_out), 32'(page));
    check_eq("trig_write", 32'(bus.write), 32'd1);
    check_eq("trig_ready", 32'(bus.ready), 32'd1);

    hold_addr = 16'($urandom);
    for (int k = 0; k < w_extra; k++) begin
      ea.push_back(16'h0100 + 16'(k));
      ew.push_back(1'b1);
      ed.push_back(8'h30 + 8'(k));
    end
    ea.push_back(hold_addr); ew.push_back(1'b0); ed.push_back(8'h00);
    // Reads begin on an even cycle: the cycle after the halt exit must be even.
    align = (((trig_cyc + 1 + w_extra) & 1) == 0);
    if (align) begin
      ea.push_back(hold_addr); ew.push_back(1'b0); ed.push_back(8'h00);
    end
    for (int i = 0; i < 256; i++) begin
      ib = 8'(i);
      ea.push_back({page, ib}); ew.push_back(1'b0); ed.push_back(8'h00);
      ea.push_back(Oam);        ew.push_back(1'b1); ed.push_back(mem[{page, ib}]);
    end

    stall = 0;
    for (int j = 0; j < ea.size(); j++) begin
      @(posedge clk);
      #1;
      if (j < w_extra) cpu_drive(ea[j], ed[j], 1'b1);
      else             cpu_drive(hold_addr, 8'($urandom), 1'b0);
      @(negedge clk);
      if (!bus.ready) stall++;
      check_eq("dma_addr", 32'(bus.addr), 32'(ea[j]));
      check_eq("dma_write", 32'(bus.write), 32'(ew[j]));
      if (ew[j]) check_eq("dma_dout", 32'(bus.d_out), 32'(ed[j]));
      check_eq("dma_busy", 32'(bus.busy), 32'd1);
    end
    check_eq("stall_len", 32'(stall), 32'(513 + w_extra + (align ? 1 : 0)));
    // ready rises the cycle after the last write; CPU traffic passes through again.
    pass_cycle(16'h0300, 8'h11, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] pg;
    int guard;

    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) mem[16'h0200 + 16'(i)] = 8'(i) ^ 8'hA5;

    cpu_drive(16'h1234, 8'h56, 1'b1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_ready", 32'(bus.ready), 32'd1);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_addr", 32'(bus.addr), 32'h1234);
    check_eq("rst_write", 32'(bus.write), 32'd1);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) pass_rand();
    // Near misses: wrong address write, and a read of the trigger address.
    pass_cycle(16'h4015, 8'h02, 1'b1);
    pass_cycle(Trig, 8'h02, 1'b0);
    pass_cycle(16'h4013, 8'h02, 1'b1);

    run_dma(8'h02, 0, 0);  // no align: 513 stall cycles
    run_dma(8'h02, 0, 1);  // align: 514 stall cycles
    for (int n = 0; n < 3; n++) begin
      pg = 8'($urandom);
      run_dma(pg, 0, int'($urandom_range(0, 1)));
      for (int i = 0; i < 3; i++) pass_rand();
    end
    run_dma(8'hFF, 0, int'($urandom_range(0, 1)));
    // No retrigger after the page wraps.
    for (int i = 0; i < 5; i++) pass_cycle(16'h0400 + 16'(i), 8'(i), 1'b0);

`ifdef OAM_DMA_HALT_ON_READ_EN
    run_dma(8'h03, 2, 0);
    run_dma(8'h03, 2, 1);
`endif

    // Abort mid-transfer at cnt=8'h40.
    @(posedge clk);
    #1;
    cpu_drive(Trig, 8'h05, 1'b1);
    @(posedge clk);
    #1;
    cpu_drive(16'h8888, 8'h00, 1'b0);
    guard = 0;
    @(negedge clk);
    while (!(bus.addr == 16'h0540 && !bus.write) && guard < 600) begin
      @(negedge clk);
      guard++;
    end
    check_eq("abort_found", 32'(guard < 600), 32'd1);
    check_eq("abort_pre_busy", 32'(bus.busy), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("abort_ready", 32'(bus.ready), 32'd1);
    check_eq("abort_busy", 32'(bus.busy), 32'd0);
    check_eq("abort_addr", 32'(bus.addr), 32'h8888);
    check_eq("abort_write", 32'(bus.write), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) pass_rand();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
